// File: rtl/fifo_word_packer.sv
// Pops bytes from the byte FIFO read port and packs them little-endian into
// words on a valid/ready master; partial words leave on idle timeout or flush.
module fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FLUSH_TIMEOUT  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fifo_empty,
  output logic                        fifo_rd,
  input  logic [7:0]                  fifo_dout,
  input  logic                        flush,
  output logic [8*BYTES_PER_WORD-1:0] m_data,
  output logic [BYTES_PER_WORD-1:0]   m_keep,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [15:0]                 word_count
);

  localparam int N  = BYTES_PER_WORD;
  localparam int IW = $clog2(N + 1);
  localparam int CW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDX_FULL = IW'(N);
  localparam logic [CW-1:0] IDLE_MAX = CW'(FLUSH_TIMEOUT);

  logic [8*N-1:0] acc_q, acc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           pend_q;
  logic [8*N-1:0] mdata_q, mdata_d;
  logic [N-1:0]   mkeep_q, mkeep_d;
  logic           mvalid_q, mvalid_d;
  logic [15:0]    count_q, count_d;
  logic [CW-1:0]  idle_q, idle_d;
  logic           flushReq_q, flushReq_d;

  logic           slotFree;
  logic           timeoutHit;
  logic           flushPending;
  logic           doMove;
  logic [IW-1:0]  fill;
  logic [8*N-1:0] accCap;
  logic [N-1:0]   keepCap;

  // fill counts the in-flight byte too, so a read is only issued when its
  // byte is guaranteed a lane (current word or lane 0 of the next one).
  always_comb begin
    slotFree     = !mvalid_q || m_ready;
    fill         = idx_q + IW'(pend_q);
    timeoutHit   = (FLUSH_TIMEOUT != 0) && (idle_q == IDLE_MAX);
    flushPending = flush || flushReq_q || timeoutHit;
    fifo_rd      = rst_n && !fifo_empty &&
                   ((fill < IDX_FULL) || ((fill == IDX_FULL) && slotFree));

    accCap  = acc_q;
    keepCap = '0;
    for (int l = 0; l < N; l++) begin
      if (pend_q && (idx_q == IW'(l))) begin
        accCap[8*l +: 8] = fifo_dout;
      end
      keepCap[l] = (IW'(l) < fill);
      if (!keepCap[l]) begin
        accCap[8*l +: 8] = 8'h00;
      end
    end

    doMove = slotFree &&
             ((fill == IDX_FULL) || (!pend_q && (idx_q != '0) && flushPending));
  end

  always_comb begin
    acc_d      = doMove ? '0 : accCap;
    idx_d      = doMove ? '0 : fill;
    mdata_d    = mdata_q;
    mkeep_d    = mkeep_q;
    mvalid_d   = mvalid_q && !m_ready;
    count_d    = count_q + 16'(mvalid_q && m_ready);
    flushReq_d = flushReq_q;
    idle_d     = idle_q;

    if (doMove) begin
      mdata_d  = accCap;
      mkeep_d  = keepCap;
      mvalid_d = 1'b1;
    end

    // A request arriving with nothing accumulated or in flight is dropped.
    if (doMove) begin
      flushReq_d = 1'b0;
    end else if (flush && ((idx_q != '0) || pend_q)) begin
      flushReq_d = 1'b1;
    end

    if (pend_q || doMove) begin
      idle_d = '0;
    end else if ((idx_q != '0) && fifo_empty && (idle_q != IDLE_MAX)) begin
      idle_d = idle_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      mdata_q    <= '0;
      mkeep_q    <= '0;
      mvalid_q   <= 1'b0;
      count_q    <= '0;
      idle_q     <= '0;
      flushReq_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      pend_q     <= fifo_rd;
      mdata_q    <= mdata_d;
      mkeep_q    <= mkeep_d;
      mvalid_q   <= mvalid_d;
      count_q    <= count_d;
      idle_q     <= idle_d;
      flushReq_q <= flushReq_d;
    end
  end

  assign m_data     = mdata_q;
  assign m_keep     = mkeep_q;
  assign m_valid    = mvalid_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: a queue stands in for the byte
// FIFO and expected words are built by grouping pushed bytes little-endian.
module tb_fifo_word_packer;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int WW = 8 * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [7:0]    fifo_dout;
  logic          flush;
  logic [WW-1:0] m_data;
  logic [N-1:0]  m_keep;
  logic          m_valid;
  logic          m_ready;
  logic [15:0]   word_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]    fq[$];
  logic [7:0]    expBytes[$];
  logic [WW-1:0] rcvData[$];
  logic [N-1:0]  rcvKeep[$];

  logic          obsRd;
  logic          obsValid;
  logic          obsReady;
  logic [WW-1:0] obsData;
  logic [N-1:0]  obsKeep;

  fifo_word_packer #(
    .BYTES_PER_WORD(N),
    .FLUSH_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_dout (fifo_dout),
    .flush     (flush),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // One clock cycle: sample mid-cycle, then model the registered FIFO read
  // port and record every word the downstream side accepted.
  task automatic tick();
    #3;
    obsRd    = fifo_rd;
    obsValid = m_valid;
    obsReady = m_ready;
    obsData  = m_data;
    obsKeep  = m_keep;
    @(posedge clk);
    #1;
    cyc++;
    if (obsRd && fq.size() > 0) fifo_dout = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    flush = 1'b0;
    if (obsValid && obsReady) begin
      rcvData.push_back(obsData);
      rcvKeep.push_back(obsKeep);
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    fq.push_back(b);
    expBytes.push_back(b);
    fifo_empty = 1'b0;
  endtask

  function automatic logic [WW-1:0] packBytes(input int start, input int cnt);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < cnt; i++) w = w | (WW'(expBytes[start + i]) << (8 * i));
    return w;
  endfunction

  task automatic doReset();
    rst_n      = 1'b0;
    fifo_empty = 1'b1;
    flush      = 1'b0;
    m_ready    = 1'b0;
    fq.delete();
    expBytes.delete();
    rcvData.delete();
    rcvKeep.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    fifo_empty = 1'b0;
    flush      = 1'b0;
    m_ready    = 1'b0;
    fifo_dout  = 8'h00;
    #2;
    checks++; if (fifo_rd !== 1'b0) begin failures++; $display("[TB] FAIL rst_rd: got %b expected 0", fifo_rd); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== '0) begin failures++; $display("[TB] FAIL rst_data: got %h expected 0", m_data); end
    checks++; if (m_keep !== '0) begin failures++; $display("[TB] FAIL rst_keep: got %h expected 0", m_keep); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("[TB] FAIL rst_count: got %0d expected 0", word_count); end
    doReset();
  endtask

  task automatic test_word_pack();
    int lastRd = -1;
    int vcyc = -1;
    logic [WW-1:0] d = '0;
    logic [N-1:0] k = '0;
    doReset();
    pushByte(8'h11); pushByte(8'h22); pushByte(8'h33); pushByte(8'h44);
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (obsRd) lastRd = c;
      if (obsValid && vcyc < 0) begin vcyc = c; d = obsData; k = obsKeep; end
    end
    checks++; if (d !== 32'h44332211) begin failures++; $display("[TB] FAIL wp_data: got %h expected 44332211", d); end
    checks++; if (k !== 4'hF) begin failures++; $display("[TB] FAIL wp_keep: got %h expected f", k); end
    checks++; if (vcyc != lastRd + 2) begin failures++; $display("[TB] FAIL wp_latency: valid cycle %0d expected %0d", vcyc, lastRd + 2); end
    checks++; if (word_count !== 16'd1) begin failures++; $display("[TB] FAIL wp_count: got %0d expected 1", word_count); end
  endtask

  task automatic test_streaming();
    int firstRd = -1;
    int lastRd = -1;
    int rdCnt = 0;
    logic [WW-1:0] got;
    doReset();
    for (int i = 0; i < 16; i++) pushByte(8'(i));
    m_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (obsRd) begin
        if (firstRd < 0) firstRd = c;
        lastRd = c;
        rdCnt++;
      end
    end
    checks++; if (rdCnt != 16) begin failures++; $display("[TB] FAIL st_rdcount: got %0d expected 16", rdCnt); end
    checks++; if (lastRd - firstRd != 15) begin failures++; $display("[TB] FAIL st_rdspan: got %0d expected 15", lastRd - firstRd); end
    checks++; if (rcvData.size() != 4) begin failures++; $display("[TB] FAIL st_words: got %0d expected 4", rcvData.size()); end
    for (int w = 0; w < 4; w++) begin
      got = (w < rcvData.size()) ? rcvData[w] : 'x;
      checks++; if (got !== packBytes(4 * w, 4)) begin failures++; $display("[TB] FAIL st_word%0d: got %h expected %h", w, got, packBytes(4 * w, 4)); end
    end
    checks++; if (word_count !== 16'd4) begin failures++; $display("[TB] FAIL st_count: got %0d expected 4", word_count); end
  endtask

  task automatic test_backpressure();
    int rdCnt = 0;
    int validCnt = 0;
    int holdBad = 0;
    logic [WW-1:0] got;
    logic [N-1:0] gotKeep;
    doReset();
    for (int i = 0; i < 16; i++) pushByte(8'(i));
    m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (obsRd) rdCnt++;
      if (obsValid) begin
        validCnt++;
        if (obsData !== 32'h03020100) holdBad++;
      end
    end
    checks++; if (rdCnt != 8) begin failures++; $display("[TB] FAIL bp_rdcount: got %0d expected 8", rdCnt); end
    checks++; if (fq.size() != 8) begin failures++; $display("[TB] FAIL bp_fifo_left: got %0d expected 8", fq.size()); end
    checks++; if (validCnt == 0 || holdBad != 0) begin failures++; $display("[TB] FAIL bp_hold: valid cycles %0d unstable cycles %0d expected >0 and 0", validCnt, holdBad); end
    m_ready = 1'b1;
    for (int c = 0; c < 30; c++) tick();
    checks++; if (rcvData.size() != 4) begin failures++; $display("[TB] FAIL bp_words: got %0d expected 4", rcvData.size()); end
    for (int w = 0; w < 4; w++) begin
      got = (w < rcvData.size()) ? rcvData[w] : 'x;
      gotKeep = (w < rcvKeep.size()) ? rcvKeep[w] : 'x;
      checks++; if (got !== packBytes(4 * w, 4) || gotKeep !== 4'hF) begin failures++; $display("[TB] FAIL bp_word%0d: got %h/%h expected %h/f", w, got, gotKeep, packBytes(4 * w, 4)); end
    end
    checks++; if (word_count !== 16'd4) begin failures++; $display("[TB] FAIL bp_count: got %0d expected 4", word_count); end
  endtask

  task automatic test_timeout();
    int lastRd = -1;
    int vcyc = -1;
    logic [WW-1:0] d = '0;
    logic [N-1:0] k = '0;
    doReset();
    pushByte(8'hAA); pushByte(8'hBB); pushByte(8'hCC);
    m_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (obsRd) lastRd = c;
      if (obsValid && vcyc < 0) begin vcyc = c; d = obsData; k = obsKeep; end
    end
    // Last read at lastRd, captured one cycle later; TO+1 cycles after that.
    checks++; if (vcyc != lastRd + TO + 3) begin failures++; $display("[TB] FAIL to_latency: valid cycle %0d expected %0d", vcyc, lastRd + TO + 3); end
    checks++; if (d !== 32'h00CCBBAA) begin failures++; $display("[TB] FAIL to_data: got %h expected 00ccbbaa", d); end
    checks++; if (k !== 4'h7) begin failures++; $display("[TB] FAIL to_keep: got %h expected 7", k); end
    checks++; if (word_count !== 16'd1) begin failures++; $display("[TB] FAIL to_count: got %0d expected 1", word_count); end
  endtask

  task automatic test_flush();
    int vcount = 0;
    doReset();
    pushByte(8'h5A); pushByte(8'hA5);
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    flush = 1'b1;
    tick();
    checks++; if (obsValid !== 1'b0) begin failures++; $display("[TB] FAIL fl_early: got %b expected 0", obsValid); end
    tick();
    checks++; if (obsValid !== 1'b1) begin failures++; $display("[TB] FAIL fl_valid: got %b expected 1", obsValid); end
    checks++; if (obsData !== 32'h0000A55A) begin failures++; $display("[TB] FAIL fl_data: got %h expected 0000a55a", obsData); end
    checks++; if (obsKeep !== 4'h3) begin failures++; $display("[TB] FAIL fl_keep: got %h expected 3", obsKeep); end
    for (int c = 0; c < 3; c++) begin tick(); if (obsValid) vcount++; end
    flush = 1'b1;
    for (int c = 0; c < 16; c++) begin tick(); if (obsValid) vcount++; end
    checks++; if (vcount != 0) begin failures++; $display("[TB] FAIL fl_empty: got %0d valid cycles expected 0", vcount); end
    checks++; if (word_count !== 16'd1) begin failures++; $display("[TB] FAIL fl_count: got %0d expected 1", word_count); end
  endtask

  task automatic test_reset_mid_word();
    logic [WW-1:0] got;
    doReset();
    for (int i = 0; i < 6; i++) pushByte(8'hE0 + 8'(i));
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    checks++; if (word_count !== 16'd1) begin failures++; $display("[TB] FAIL rm_pre_count: got %0d expected 1", word_count); end
    expBytes.delete();
    rcvData.delete();
    rcvKeep.delete();
    for (int i = 1; i <= 4; i++) pushByte(8'(i));
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_rd !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_ctrl: got rd=%b valid=%b expected 0/0", fifo_rd, m_valid); end
    checks++; if (m_data !== '0 || m_keep !== '0) begin failures++; $display("[TB] FAIL rm_data: got %h/%h expected 0/0", m_data, m_keep); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("[TB] FAIL rm_count: got %0d expected 0", word_count); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) tick();
    got = (rcvData.size() > 0) ? rcvData[0] : 'x;
    checks++; if (rcvData.size() != 1) begin failures++; $display("[TB] FAIL rm_words: got %0d expected 1", rcvData.size()); end
    checks++; if (got !== 32'h04030201) begin failures++; $display("[TB] FAIL rm_word: got %h expected 04030201", got); end
    checks++; if (rcvKeep.size() == 0 || rcvKeep[0] !== 4'hF) begin failures++; $display("[TB] FAIL rm_keep: got %0d words expected keep f", rcvKeep.size()); end
    checks++; if (word_count !== 16'd1) begin failures++; $display("[TB] FAIL rm_post_count: got %0d expected 1", word_count); end
  endtask

  task automatic test_random();
    int total;
    int pushed = 0;
    int since = 0;
    int holdBad = 0;
    logic prevValid = 1'b0;
    logic prevReady = 1'b0;
    logic [WW-1:0] prevData = '0;
    logic [WW-1:0] got;
    logic [N-1:0] gotKeep;
    doReset();
    total = N * $urandom_range(6, 10);
    for (int c = 0; c < 400; c++) begin
      // Never leave the FIFO empty long enough for the idle timeout to fire.
      if (pushed < total && fq.size() < 16 && ($urandom_range(0, 3) != 0 || since >= 2)) begin
        pushByte(8'($urandom));
        pushed++;
        since = 0;
      end else begin
        since++;
      end
      m_ready = 1'($urandom_range(0, 1));
      tick();
      if (prevValid && !prevReady && (obsValid !== 1'b1 || obsData !== prevData)) holdBad++;
      prevValid = obsValid;
      prevReady = obsReady;
      prevData  = obsData;
    end
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    checks++; if (holdBad != 0) begin failures++; $display("[TB] FAIL rnd_hold: got %0d unstable cycles expected 0", holdBad); end
    checks++; if (rcvData.size() != total / N) begin failures++; $display("[TB] FAIL rnd_words: got %0d expected %0d", rcvData.size(), total / N); end
    for (int w = 0; w < total / N; w++) begin
      got = (w < rcvData.size()) ? rcvData[w] : 'x;
      gotKeep = (w < rcvKeep.size()) ? rcvKeep[w] : 'x;
      checks++; if (got !== packBytes(N * w, N) || gotKeep !== 4'hF) begin failures++; $display("[TB] FAIL rnd_word%0d: got %h/%h expected %h/f", w, got, gotKeep, packBytes(N * w, N)); end
    end
    checks++; if (word_count !== 16'(total / N)) begin failures++; $display("[TB] FAIL rnd_count: got %0d expected %0d", word_count, total / N); end
  endtask

  initial begin
    test_reset();
    test_word_pack();
    test_streaming();
    test_backpressure();
    test_timeout();
    test_flush();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
